// File: rtl/global_types.sv
// Shared opcode and divider-state types for the execute-stage multiply/divide unit.
package global_types;

   // Multiply/divide opcode carried by the instruction in execute
   typedef enum logic [3:0] {
      OP_NOP   = 4'd0,
      OP_MULT  = 4'd1,
      OP_MULTU = 4'd2,
      OP_DIV   = 4'd3,
      OP_DIVU  = 4'd4,
      OP_MTHI  = 4'd5,
      OP_MTLO  = 4'd6,
      OP_MFHI  = 4'd7,
      OP_MFLO  = 4'd8
   } muldiv_op_t;

   // Control state of the iterative divide sequence
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      DIV_RUN = 2'd1,
      DIV_FIX = 2'd2
   } div_state_t;

   // True for every opcode that reads or writes HI/LO and must wait for a running divide
   function automatic logic uses_hilo(input logic [3:0] op);
      return (op >= 4'd1) && (op <= 4'd8);
   endfunction

endpackage

// File: rtl/restoring_divider.sv
// Unsigned restoring divider: one quotient bit per cycle, ITERS cycles after i_start.
// o_done is high during the cycle whose closing edge performs the final step, so the
// quotient/remainder outputs are valid from the following cycle until the next start.
module restoring_divider #(
   parameter int WIDTH = 32,
   parameter int ITERS = WIDTH
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_dividend,
   input  logic [WIDTH-1:0] i_divisor,
   output logic             o_done,
   output logic [WIDTH-1:0] o_quotient,
   output logic [WIDTH-1:0] o_remainder
);

   localparam int CW = (ITERS > 1) ? $clog2(ITERS) : 1;

   logic             r_run;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] r_quo;
   logic [WIDTH-1:0] r_div;
   logic [WIDTH:0]   w_trial;
   logic             w_last;

   // Trial subtraction of the divisor from the remainder shifted left by the next dividend bit
   always_comb begin
      w_trial = {r_rem, r_quo[WIDTH-1]} - {1'b0, r_div};
      w_last  = r_run && (r_cnt == CW'(ITERS - 1));
   end

   assign o_done      = w_last;
   assign o_quotient  = r_quo;
   assign o_remainder = r_rem;

   // Dividend shifts out of r_quo's top as quotient bits shift in at the bottom
   always_ff @(posedge clock) begin
      if (reset) begin
         r_run <= 1'b0;
         r_cnt <= '0;
         r_rem <= '0;
         r_quo <= '0;
         r_div <= '0;
      end else if (i_start) begin
         r_run <= 1'b1;
         r_cnt <= '0;
         r_rem <= '0;
         r_quo <= i_dividend;
         r_div <= i_divisor;
      end else if (r_run) begin
         if (!w_trial[WIDTH]) begin
            r_rem <= w_trial[WIDTH-1:0];
            r_quo <= {r_quo[WIDTH-2:0], 1'b1};
         end else begin
            r_rem <= {r_rem[WIDTH-2:0], r_quo[WIDTH-1]};
            r_quo <= {r_quo[WIDTH-2:0], 1'b0};
         end
         r_cnt <= r_cnt + CW'(1);
         if (w_last) r_run <= 1'b0;
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// Execute-stage multiply/divide unit owning HI/LO. Multiplies complete in the accepting
// cycle; divides run on restoring_divider and request a pipeline stall while a dependent
// HI/LO instruction waits. Valid/ready view: an op is taken on an edge where
// e_op != OP_NOP, e_flush == 0 and stall_req == 0; stall_req is the "not ready" signal.
module muldiv_unit
   import global_types::*;
#(
   parameter int WIDTH = 32,
   parameter int ITERS = WIDTH
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [3:0]       e_op,
   input  logic [WIDTH-1:0] e_a,
   input  logic [WIDTH-1:0] e_b,
   input  logic             e_flush,
   output logic [WIDTH-1:0] e_hilo_rd,
   output logic             busy,
   output logic             stall_req
);

   div_state_t         r_state, w_state_next;
   logic [WIDTH-1:0]   r_hi, r_lo, r_a_raw;
   logic               r_sign_q, r_sign_r, r_div0;

   muldiv_op_t         w_op;
   logic               w_accept, w_is_div, w_signed_div, w_start, w_mul_sx, w_div_done;
   logic [WIDTH-1:0]   w_a_mag, w_b_mag, w_quo, w_rem, w_q_fix, w_r_fix;
   logic [2*WIDTH-1:0] w_prod;

   // Decode, stall request, operand magnitudes and the single-cycle product
   always_comb begin
      w_op         = muldiv_op_t'(e_op);
      busy         = (r_state != IDLE);
      stall_req    = busy & uses_hilo(e_op) & ~e_flush;
      w_accept     = (w_op != OP_NOP) & ~e_flush & ~stall_req;
      w_is_div     = (w_op == OP_DIV) || (w_op == OP_DIVU);
      w_signed_div = (w_op == OP_DIV);
      w_start      = w_accept & w_is_div;
      w_a_mag      = (w_signed_div & e_a[WIDTH-1]) ? -e_a : e_a;
      w_b_mag      = (w_signed_div & e_b[WIDTH-1]) ? -e_b : e_b;
      w_mul_sx     = (w_op == OP_MULT);
      w_prod       = {{WIDTH{w_mul_sx & e_a[WIDTH-1]}}, e_a} *
                     {{WIDTH{w_mul_sx & e_b[WIDTH-1]}}, e_b};
   end

   restoring_divider #(.WIDTH(WIDTH), .ITERS(ITERS)) u_div (
      .clock       (clock),
      .reset       (reset),
      .i_start     (w_start),
      .i_dividend  (w_a_mag),
      .i_divisor   (w_b_mag),
      .o_done      (w_div_done),
      .o_quotient  (w_quo),
      .o_remainder (w_rem)
   );

   // Sign fixup of the magnitude result; divide-by-zero bypasses it entirely
   always_comb begin
      w_q_fix = r_sign_q ? -w_quo : w_quo;
      w_r_fix = r_sign_r ? -w_rem : w_rem;
      if (r_div0) begin
         w_q_fix = '1;
         w_r_fix = r_a_raw;
      end
   end

   // HI/LO read port for MFHI/MFLO, zero otherwise
   always_comb begin
      e_hilo_rd = '0;
      if (w_op == OP_MFHI) e_hilo_rd = r_hi;
      else if (w_op == OP_MFLO) e_hilo_rd = r_lo;
   end

   // Divide sequence state register
   always_ff @(posedge clock) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_state_next;
   end

   // Divide sequence next-state logic
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (w_start) w_state_next = DIV_RUN;
         DIV_RUN: if (w_div_done) w_state_next = DIV_FIX;
         DIV_FIX: w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   // HI/LO and divide context: divide completion outranks any newly accepted op
   always_ff @(posedge clock) begin
      if (reset) begin
         r_hi     <= '0;
         r_lo     <= '0;
         r_a_raw  <= '0;
         r_sign_q <= 1'b0;
         r_sign_r <= 1'b0;
         r_div0   <= 1'b0;
      end else if (r_state == DIV_FIX) begin
         r_lo <= w_q_fix;
         r_hi <= w_r_fix;
      end else if (w_accept) begin
         case (w_op)
            OP_MULT, OP_MULTU: begin
               r_hi <= w_prod[2*WIDTH-1:WIDTH];
               r_lo <= w_prod[WIDTH-1:0];
            end
            OP_MTHI: r_hi <= e_a;
            OP_MTLO: r_lo <= e_a;
            OP_DIV, OP_DIVU: begin
               r_a_raw  <= e_a;
               r_sign_q <= w_signed_div & (e_a[WIDTH-1] ^ e_b[WIDTH-1]);
               r_sign_r <= w_signed_div & e_a[WIDTH-1];
               r_div0   <= (e_b == '0);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: an ISA-level HI/LO model predicts every MFHI/MFLO result at issue
// time; a negedge monitor pops and compares whenever the unit actually takes the read.
module tb_muldiv_unit;
  import global_types::*;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  muldiv_op_t  e_op;
  logic [31:0] e_a, e_b;
  logic        e_flush;
  logic [31:0] e_hilo_rd;
  logic        busy, stall_req;

  muldiv_unit #(.WIDTH(32), .ITERS(32)) dut (
    .clock     (clock),
    .reset     (reset),
    .e_op      (e_op),
    .e_a       (e_a),
    .e_b       (e_b),
    .e_flush   (e_flush),
    .e_hilo_rd (e_hilo_rd),
    .busy      (busy),
    .stall_req (stall_req)
  );

  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] m_hi, m_lo;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model_apply(input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b);
    longint          p;
    longint unsigned pu;
    int              sa, sb;
    sa = a;
    sb = b;
    case (op)
      OP_MULT: begin
        p = longint'(sa) * longint'(sb);
        m_hi = p[63:32];
        m_lo = p[31:0];
      end
      OP_MULTU: begin
        pu = {32'b0, a} * {32'b0, b};
        m_hi = pu[63:32];
        m_lo = pu[31:0];
      end
      OP_DIV: begin
        if (b == 0) begin
          m_lo = 32'hFFFF_FFFF;
          m_hi = a;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          m_lo = 32'h8000_0000;
          m_hi = 32'h0;
        end else begin
          m_lo = sa / sb;
          m_hi = sa % sb;
        end
      end
      OP_DIVU: begin
        if (b == 0) begin
          m_lo = 32'hFFFF_FFFF;
          m_hi = a;
        end else begin
          m_lo = a / b;
          m_hi = a % b;
        end
      end
      OP_MTHI: m_hi = a;
      OP_MTLO: m_lo = a;
      OP_MFHI: exp_q.push_back(m_hi);
      OP_MFLO: exp_q.push_back(m_lo);
      default: ;
    endcase
  endtask

  // ---------------- driver ----------------
  // Presents one op and holds it while stall_req is high; returns one cycle after it is taken.
  task automatic issue(input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b,
                       input logic fl, output int stalls);
    e_op = op;
    e_a = a;
    e_b = b;
    e_flush = fl;
    if (!fl) model_apply(op, a, b);
    stalls = 0;
    @(negedge clock);
    while (stall_req && stalls < 100) begin
      stalls++;
      @(negedge clock);
    end
    if (stalls >= 100) begin
      total++;
      bad++;
      $display("FAIL stall_timeout: stall_req still high after %0d cycles", stalls);
    end
    @(posedge clock);
    #1;
    e_op = OP_NOP;
    e_flush = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom();
    endcase
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clock) begin
    if (!reset && !e_flush && !stall_req && (e_op == OP_MFHI || e_op == OP_MFLO)) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL hilo_rd: got %h with no expected value queued", e_hilo_rd);
      end else begin
        check("hilo_rd", e_hilo_rd, exp_q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int st;
    muldiv_op_t rop;
    reset = 1'b1;
    e_op = OP_NOP;
    e_a = '0;
    e_b = '0;
    e_flush = 1'b0;
    m_hi = '0;
    m_lo = '0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    check("reset_busy", {31'b0, busy}, 32'h0);
    check("reset_stall", {31'b0, stall_req}, 32'h0);
    issue(OP_MFHI, 0, 0, 0, st);
    issue(OP_MFLO, 0, 0, 0, st);

    // multiply, signed and unsigned
    issue(OP_MULT, 32'hFFFF_FFFF, 32'h2, 0, st);
    check("mult_busy", {31'b0, busy}, 32'h0);
    issue(OP_MFHI, 0, 0, 0, st);
    issue(OP_MFLO, 0, 0, 0, st);
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'h2, 0, st);
    check("multu_busy", {31'b0, busy}, 32'h0);
    issue(OP_MFHI, 0, 0, 0, st);
    issue(OP_MFLO, 0, 0, 0, st);

    // DIVU latency with a dependent read held in execute
    issue(OP_DIVU, 32'd100, 32'd7, 0, st);
    check("divu_busy", {31'b0, busy}, 32'h1);
    issue(OP_MFLO, 0, 0, 0, st);
    check("divu_stall_cycles", 32'(st), 32'd33);
    issue(OP_MFHI, 0, 0, 0, st);
    check("mfhi_no_stall", 32'(st), 32'd0);

    // signed divide, overflow and divide by zero
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 0, st);
    issue(OP_MFLO, 0, 0, 0, st);
    issue(OP_MFHI, 0, 0, 0, st);
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, st);
    issue(OP_MFLO, 0, 0, 0, st);
    issue(OP_MFHI, 0, 0, 0, st);
    issue(OP_DIVU, 32'd5, 32'd0, 0, st);
    issue(OP_MFLO, 0, 0, 0, st);
    issue(OP_MFHI, 0, 0, 0, st);
    issue(OP_DIV, 32'hFFFF_FFFB, 32'd0, 0, st);
    issue(OP_MFLO, 0, 0, 0, st);
    issue(OP_MFHI, 0, 0, 0, st);

    // reset in cycle 10 of a divide
    issue(OP_DIVU, 32'd100, 32'd7, 0, st);
    repeat (8) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    m_hi = '0;
    m_lo = '0;
    check("midreset_busy", {31'b0, busy}, 32'h0);
    issue(OP_MFLO, 0, 0, 0, st);
    check("midreset_stall", 32'(st), 32'd0);
    issue(OP_MFHI, 0, 0, 0, st);

    // flushed divide never starts; MTHI then MFHI
    issue(OP_DIV, 32'd50, 32'd3, 1, st);
    check("flush_busy", {31'b0, busy}, 32'h0);
    issue(OP_MFHI, 0, 0, 0, st);
    issue(OP_MFLO, 0, 0, 0, st);
    issue(OP_MTHI, 32'h1234, 0, 0, st);
    issue(OP_MFHI, 0, 0, 0, st);
    check("mthi_mfhi_stall", 32'(st), 32'd0);

    // flush of a later instruction does not abort a running divide
    issue(OP_DIVU, 32'd1000, 32'd3, 0, st);
    issue(OP_MFLO, 0, 0, 1, st);
    check("flush_keeps_busy", {31'b0, busy}, 32'h1);
    issue(OP_MFLO, 0, 0, 0, st);
    issue(OP_MFHI, 0, 0, 0, st);

    // randomized mix
    for (int i = 0; i < 300; i++) begin
      rop = muldiv_op_t'($urandom_range(0, 8));
      issue(rop, pick(), pick(), ($urandom_range(0, 7) == 0), st);
    end
    issue(OP_MFHI, 0, 0, 0, st);
    issue(OP_MFLO, 0, 0, 0, st);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
